out_uart_tx: RTL

OUT_UART_TX -- requirements
Module: out_uart_tx

---
 rtl/risc_v_pkg.sv | 14 +
 rtl/out_uart_tx_word_fifo.sv | 52 +++++
 rtl/out_uart_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/risc_v_pkg.sv
// Shared definitions for the CPU output UART: transmitter states and frame geometry.
package risc_v_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/out_uart_tx_word_fifo.sv
// Synchronous show-ahead FIFO; a push on a full FIFO is accepted only when a pop happens the same edge.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally modulo DEPTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/out_uart_tx.sv
// Captures every change of the CPU out value and ships each 32-bit word as four 8N1 bytes, LSB first.
module out_uart_tx
  import risc_v_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] out_word,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int               FCNT_W   = $clog2(FIFO_DEPTH) + 1;

  uart_state_e       state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       prev;
  logic [31:0]       word;
  logic [7:0]        shreg;
  logic [7:0]        cur_byte;
  logic [31:0]       fifo_data;
  logic [FCNT_W-1:0] fifo_count;
  logic              capture;
  logic              pop;
  logic              full;
  logic              empty;
  logic              bit_end;
  logic              word_end;

  assign capture  = (out_word != prev);
  assign bit_end  = (bit_cnt == CNT_LAST);
  assign word_end = (state == STOP) && bit_end && (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign pop      = !empty && ((state == IDLE) || word_end);
  assign busy     = (state != IDLE) || (fifo_count != '0);
  assign cur_byte = word[{byte_idx, 3'b000} +: 8];

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (capture),
    .pop     (pop),
    .wr_data (out_word),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      prev     <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      prev <= out_word;
      if (capture && full && !pop) overflow <= 1'b1;
      bit_cnt <= ((state == IDLE) || bit_end) ? '0 : bit_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state    <= START;
            byte_idx <= '0;
            tx       <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= cur_byte[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'(BITS_PER_BYTE - 1)) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shreg[0];
          end
        end
        STOP: if (bit_end) begin
          // Bytes of one word and consecutive queued words go out back to back
          if (!word_end) begin
            byte_idx <= byte_idx + 1'b1;
            state    <= START;
            tx       <= 1'b0;
          end else if (!empty) begin
            byte_idx <= '0;
            state    <= START;
            tx       <= 1'b0;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // shreg holds the not-yet-sent bits of the current byte; bit 0 leaves straight from cur_byte
  always_ff @(posedge clock) begin
    if (pop) word <= fifo_data;
    if ((state == START) && bit_end)     shreg <= cur_byte >> 1;
    else if ((state == DATA) && bit_end) shreg <= shreg >> 1;
  end

endmodule
